// File: rtl/led_step_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : led_step_ctrl                                                   |
// | Purpose  : Up/down step counter driven by two debounced keys, with         |
// |            press-and-hold auto-repeat and an LED mirror of the count.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk         in   1      clock, rising edge                               |
// |   rst_n       in   1      asynchronous active-low reset                    |
// |   key_flag0   in   1      up-key level-change pulse                        |
// |   key_state0  in   1      up-key debounced level (0 = pressed)             |
// |   key_flag1   in   1      down-key level-change pulse                      |
// |   key_state1  in   1      down-key debounced level (0 = pressed)           |
// |   count       out  WIDTH  registered counter value                         |
// |   led         out  WIDTH  LED drive (inverted count when LED_ACTIVE_LOW)   |
// |   at_max      out  1      count is all-ones                                |
// |   at_min      out  1      count is zero                                    |
// +----------------------------------------------------------------------------+
module led_step_ctrl #(
    parameter int WIDTH          = 4,
    parameter int STEP           = 1,
    parameter int SAT_MODE       = 0,
    parameter int HOLD_CYCLES    = 8,
    parameter int REPEAT_CYCLES  = 4,
    parameter int LED_ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_flag0,
    input  logic             key_state0,
    input  logic             key_flag1,
    input  logic             key_state1,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] led,
    output logic             at_max,
    output logic             at_min
);

    // The timer only has to reach (max period - 1); with HOLD_CYCLES >= 2
    // that always fits in clog2(max period) bits.
    localparam int c_tmr_max = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int c_tmr_w   = (c_tmr_max > 1) ? $clog2(c_tmr_max) : 1;

    localparam logic [c_tmr_w-1:0] c_hold_last = c_tmr_w'(HOLD_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_rpt_last  = c_tmr_w'(REPEAT_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_tmr_one   = c_tmr_w'(1);
    localparam logic [WIDTH:0]     c_step      = (WIDTH + 1)'(STEP);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HOLD_UP = 3'd1,
        S_HOLD_DN = 3'd2,
        S_RPT_UP  = 3'd3,
        S_RPT_DN  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_tmr_w-1:0] r_timer;
    logic [c_tmr_w-1:0] w_timer_nxt;
    logic [WIDTH-1:0]   r_count;
    logic [WIDTH-1:0]   w_count_nxt;

    logic               w_up_press;
    logic               w_dn_press;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_up_val;
    logic [WIDTH-1:0]   w_dn_val;

    // A press is a level change whose new level is "pressed"; release
    // pulses (flag with state = 1) are not presses.
    assign w_up_press = key_flag0 && !key_state0;
    assign w_dn_press = key_flag1 && !key_state1;

    // One extra bit exposes the carry/borrow used for saturation.
    always_comb begin
        w_sum  = {1'b0, r_count} + c_step;
        w_diff = {1'b0, r_count} - c_step;
        if (SAT_MODE != 0) begin
            w_up_val = w_sum[WIDTH]  ? '1 : w_sum[WIDTH-1:0];
            w_dn_val = w_diff[WIDTH] ? '0 : w_diff[WIDTH-1:0];
        end else begin
            w_up_val = w_sum[WIDTH-1:0];
            w_dn_val = w_diff[WIDTH-1:0];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_count_nxt = r_count;
        case (r_state)
            S_IDLE: begin
                if (w_up_press && w_dn_press) begin
                    w_count_nxt = '0;
                end else if (w_up_press) begin
                    w_count_nxt = w_up_val;
                    w_state_nxt = S_HOLD_UP;
                    w_timer_nxt = '0;
                end else if (w_dn_press) begin
                    w_count_nxt = w_dn_val;
                    w_state_nxt = S_HOLD_DN;
                    w_timer_nxt = '0;
                end
            end
            // Release is checked first so it wins over a coinciding expiry.
            S_HOLD_UP: begin
                if (key_state0) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                end else if (r_timer == c_hold_last) begin
                    w_count_nxt = w_up_val;
                    w_state_nxt = S_RPT_UP;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + c_tmr_one;
                end
            end
            S_HOLD_DN: begin
                if (key_state1) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                end else if (r_timer == c_hold_last) begin
                    w_count_nxt = w_dn_val;
                    w_state_nxt = S_RPT_DN;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + c_tmr_one;
                end
            end
            S_RPT_UP: begin
                if (key_state0) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                end else if (r_timer == c_rpt_last) begin
                    w_count_nxt = w_up_val;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + c_tmr_one;
                end
            end
            S_RPT_DN: begin
                if (key_state1) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                end else if (r_timer == c_rpt_last) begin
                    w_count_nxt = w_dn_val;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + c_tmr_one;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign count  = r_count;
    assign at_max = (r_count == {WIDTH{1'b1}});
    assign at_min = (r_count == '0);

    generate
        if (LED_ACTIVE_LOW != 0) begin : g_led_inv
            assign led = ~r_count;
        end else begin : g_led_true
            assign led = r_count;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_led_step_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_led_step_ctrl                                                |
// | Purpose  : Directed self-checking bench for led_step_ctrl. Instance A uses |
// |            the default wrap configuration, instance B saturates with      |
// |            STEP=3 and an active-high LED.                                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_led_step_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] flag0, state0, flag1, state1;
    logic [3:0] count_a, led_a, count_b, led_b;
    logic       at_max_a, at_min_a, at_max_b, at_min_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    led_step_ctrl #(
        .WIDTH(4), .STEP(1), .SAT_MODE(0),
        .HOLD_CYCLES(8), .REPEAT_CYCLES(4), .LED_ACTIVE_LOW(1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .key_flag0(flag0[0]), .key_state0(state0[0]),
        .key_flag1(flag1[0]), .key_state1(state1[0]),
        .count(count_a), .led(led_a), .at_max(at_max_a), .at_min(at_min_a)
    );

    led_step_ctrl #(
        .WIDTH(4), .STEP(3), .SAT_MODE(1),
        .HOLD_CYCLES(8), .REPEAT_CYCLES(4), .LED_ACTIVE_LOW(0)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .key_flag0(flag0[1]), .key_state0(state0[1]),
        .key_flag1(flag1[1]), .key_state1(state1[1]),
        .count(count_b), .led(led_b), .at_max(at_max_b), .at_min(at_min_b)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Press pulse: flag high for one cycle with level going to pressed.
    // Returns at the negedge after the sampling edge.
    task automatic press(input int idx, input bit up);
        @(negedge clk);
        if (up) begin flag0[idx] = 1'b1; state0[idx] = 1'b0; end
        else    begin flag1[idx] = 1'b1; state1[idx] = 1'b0; end
        @(negedge clk);
        flag0[idx] = 1'b0;
        flag1[idx] = 1'b0;
    endtask

    task automatic release_key(input int idx, input bit up);
        @(negedge clk);
        if (up) begin flag0[idx] = 1'b1; state0[idx] = 1'b1; end
        else    begin flag1[idx] = 1'b1; state1[idx] = 1'b1; end
        @(negedge clk);
        flag0[idx] = 1'b0;
        flag1[idx] = 1'b0;
    endtask

    task automatic tap(input int idx, input bit up, input int hold);
        press(idx, up);
        repeat (hold - 1) @(negedge clk);
        release_key(idx, up);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n  = 1'b0;
        flag0  = '0;
        flag1  = '0;
        state0 = '1;
        state1 = '1;

        // Reset values
        @(negedge clk);
        check_val("rst_count_a", int'(count_a), 0);
        check_val("rst_led_a", int'(led_a), 15);
        check_val("rst_at_min_a", int'(at_min_a), 1);
        check_val("rst_at_max_a", int'(at_max_a), 0);
        check_val("rst_led_b", int'(led_b), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single tap: one step, no auto-repeat
        tap(0, 1'b1, 3);
        check_val("tap_count", int'(count_a), 1);
        check_val("tap_led", int'(led_a), 14);
        repeat (12) @(negedge clk);
        check_val("tap_stable", int'(count_a), 1);

        // Hold 30 clocks: steps at press+1, +9, then every 4 clocks
        do_reset();
        press(0, 1'b1);
        check_val("hold_p1", int'(count_a), 1);
        repeat (7) @(negedge clk);
        check_val("hold_p8", int'(count_a), 1);
        @(negedge clk);
        check_val("hold_p9", int'(count_a), 2);
        repeat (3) @(negedge clk);
        check_val("hold_p12", int'(count_a), 2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("hold_rpt", int'(count_a), 3 + k);
            if (k < 4) repeat (3) @(negedge clk);
        end
        release_key(0, 1'b1);
        check_val("hold_release", int'(count_a), 7);
        repeat (10) @(negedge clk);
        check_val("hold_idle", int'(count_a), 7);
        tap(0, 1'b0, 3);
        check_val("hold_then_down", int'(count_a), 6);

        // Wrap around at both ends
        do_reset();
        tap(0, 1'b0, 3);
        check_val("wrap_dn_count", int'(count_a), 15);
        check_val("wrap_dn_at_max", int'(at_max_a), 1);
        check_val("wrap_dn_led", int'(led_a), 0);
        tap(0, 1'b1, 3);
        check_val("wrap_up_count", int'(count_a), 0);
        check_val("wrap_up_at_min", int'(at_min_a), 1);
        check_val("wrap_up_at_max", int'(at_max_a), 0);

        // Simultaneous press clears; other-key press ignored during hold
        do_reset();
        for (int k = 0; k < 9; k++) tap(0, 1'b1, 2);
        check_val("sim_pre", int'(count_a), 9);
        @(negedge clk);
        flag0[0] = 1'b1; state0[0] = 1'b0;
        flag1[0] = 1'b1; state1[0] = 1'b0;
        @(negedge clk);
        flag0[0] = 1'b0; flag1[0] = 1'b0;
        check_val("sim_clear", int'(count_a), 0);
        @(negedge clk);
        flag0[0] = 1'b1; state0[0] = 1'b1;
        flag1[0] = 1'b1; state1[0] = 1'b1;
        @(negedge clk);
        flag0[0] = 1'b0; flag1[0] = 1'b0;
        repeat (10) @(negedge clk);
        check_val("sim_idle", int'(count_a), 0);
        press(0, 1'b1);
        check_val("other_up", int'(count_a), 1);
        repeat (2) @(negedge clk);
        press(0, 1'b0);
        check_val("other_dn_ignored", int'(count_a), 1);
        release_key(0, 1'b1);
        release_key(0, 1'b0);
        repeat (10) @(negedge clk);
        check_val("other_final", int'(count_a), 1);

        // Reset during auto-repeat at count 6
        do_reset();
        press(0, 1'b1);
        repeat (24) @(negedge clk);
        check_val("rrst_pre", int'(count_a), 6);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("rrst_count", int'(count_a), 0);
        check_val("rrst_led", int'(led_a), 15);
        check_val("rrst_at_min", int'(at_min_a), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_val("rrst_held", int'(count_a), 0);
        release_key(0, 1'b1);
        check_val("rrst_released", int'(count_a), 0);

        // Saturating instance, STEP=3: 0,3,6,9,12,15
        for (int k = 0; k < 5; k++) tap(1, 1'b1, 2);
        check_val("sat_reach_max", int'(count_b), 15);
        check_val("sat_led", int'(led_b), 15);
        check_val("sat_at_max", int'(at_max_b), 1);
        tap(1, 1'b1, 2);
        check_val("sat_up_clamp", int'(count_b), 15);
        press(1, 1'b1);
        repeat (20) @(negedge clk);
        check_val("sat_hold_clamp", int'(count_b), 15);
        release_key(1, 1'b1);
        tap(1, 1'b0, 2);
        check_val("sat_dn_12", int'(count_b), 12);
        for (int k = 0; k < 4; k++) tap(1, 1'b0, 2);
        check_val("sat_dn_0", int'(count_b), 0);
        tap(1, 1'b0, 2);
        check_val("sat_dn_clamp", int'(count_b), 0);
        check_val("sat_at_min", int'(at_min_b), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_step_ctrl.md
LED_STEP_CTRL -- requirements
Module: led_step_ctrl

Interface
REQ-001 Parameter WIDTH, 4: counter and LED width in bits, 1..16.
REQ-002 Parameter STEP, 1: increment/decrement per step, 1..2^WIDTH-1.
REQ-003 Parameter SAT_MODE, 0: 0 = wrap modulo 2^WIDTH, 1 = saturate at 0 and 2^WIDTH-1.
REQ-004 Parameter HOLD_CYCLES, 8: clocks from the initial step to the first auto-repeat step, >=2.
REQ-005 Parameter REPEAT_CYCLES, 4: clocks between auto-repeat steps, >=1.
REQ-006 Parameter LED_ACTIVE_LOW, 1: 1 = led is the bitwise inverse of count, 0 = led equals count.
REQ-007 clk  in  1  clock; all state updates on the rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 key_flag0  in  1  one-cycle pulse when the debounced up-key level changes.
REQ-010 key_state0  in  1  debounced up-key level; 0 = pressed.
REQ-011 key_flag1  in  1  one-cycle pulse when the debounced down-key level changes.
REQ-012 key_state1  in  1  debounced down-key level; 0 = pressed.
REQ-013 count  out  WIDTH  current counter value, registered.
REQ-014 led  out  WIDTH  LED drive derived from count per LED_ACTIVE_LOW.
REQ-015 at_max  out  1  high when count == 2^WIDTH-1.
REQ-016 at_min  out  1  high when count == 0.

Function
REQ-017 Press event: up_press = key_flag0 && !key_state0; dn_press = key_flag1 && !key_state1.
REQ-018 FSM states: IDLE, HOLD_UP, HOLD_DN, RPT_UP, RPT_DN; an internal timer counts clocks in the HOLD and RPT states.
REQ-019 IDLE, up_press only: count steps up, go to HOLD_UP, timer = 0.
REQ-020 IDLE, dn_press only: count steps down, go to HOLD_DN, timer = 0.
REQ-021 IDLE, up_press and dn_press in the same cycle: count cleared to 0; stay in IDLE.
REQ-022 Every count change is visible on count, led, at_max and at_min in the cycle after the sampling edge; there is no other latency.
REQ-023 HOLD_x: timer increments each clock; when timer == HOLD_CYCLES-1 and the key is still held, apply one step, go to RPT_x, timer = 0.
REQ-024 RPT_x: timer increments each clock; when timer == REPEAT_CYCLES-1, apply one step and set timer = 0.
REQ-025 In any HOLD_x or RPT_x state, the owning key_state being 1 returns the FSM to IDLE with timer = 0 and applies no step that cycle; this takes priority over a timer expiry.
REQ-026 While in HOLD_x or RPT_x, press events on the other key are ignored.
REQ-027 Up step with SAT_MODE=0: count = (count + STEP) mod 2^WIDTH.
REQ-028 Down step with SAT_MODE=0: count = (count - STEP) mod 2^WIDTH.
REQ-029 Steps with SAT_MODE=1: use a WIDTH+1-bit sum or difference; clamp to 2^WIDTH-1 on overflow and to 0 on underflow.
REQ-030 In saturate mode, auto-repeat continues at a clamp with count unchanged; the FSM does not exit until release.
REQ-031 Timer width is sized for max(HOLD_CYCLES, REPEAT_CYCLES); the timer never wraps before expiry.

Reset
REQ-032 While rst_n = 0: count = 0, FSM = IDLE, timer = 0; led = all-ones if LED_ACTIVE_LOW=1, else 0; at_min = 1; at_max = 0.
REQ-033 Reset asserted mid-hold or mid-repeat aborts immediately; after release, no step occurs until a new press event.

Verification
Defaults apply unless stated: WIDTH=4, STEP=1, HOLD_CYCLES=8, REPEAT_CYCLES=4.
REQ-034 Single tap, up pulse then release after 3 clocks -> count 0->1, led 4'b1110, no further change.
REQ-035 Up held 30 clocks after press -> count 1 at press+1; 2 at press+9; then +1 every 4 clocks (press+13, +17, +21, +25, +29); value 7 at release; IDLE next cycle.
REQ-036 Wrap (SAT_MODE=0), count=0, down tap -> 15, at_max=1; up tap -> 0, at_min=1.
REQ-037 Saturate (SAT_MODE=1, STEP=3): from 14, up tap -> 15; hold up -> stays 15; from 2, down tap -> 0.
REQ-038 Simultaneous up and down press at count=9 -> 0; FSM stays IDLE; down press while up is held -> ignored.
REQ-039 rst_n pulsed low during RPT_UP at count=6 -> count=0 and led=4'b1111 asynchronously; key still held after reset -> no steps.
